// File: rtl/pong_enq_arbiter.sv
// Round-robin arbiter that shares the enq port of one ping-pong FIFO among
// NREQ producers. One producer owns the port at a time for up to MAX_BURST
// beats. Only the owner's handshake is forwarded to the FIFO.
module pong_enq_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 96,
  parameter int MAX_BURST = 4,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_want_i,
  input  logic [NREQ-1:0]       req_enq_ena_i,
  input  logic [NREQ*WIDTH-1:0] req_enq_v_i,
  output logic [NREQ-1:0]       req_enq_rdy_o,
  output logic                  out_enq_ena_o,
  output logic [WIDTH-1:0]      out_enq_v_o,
  input  logic                  out_enq_rdy_i,
  output logic                  grant_valid_o,
  output logic [IDW-1:0]        grant_id_o,
  output logic                  err_proto_o
);

  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic {S_IDLE, S_OWNED} state_e;

  state_e          state_q;
  logic [IDW-1:0]  owner_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [BW-1:0]   burst_q;
  logic            err_q;

  logic            owned;
  logic            fire;
  logic            last_beat;
  logic            release_d;
  logic [IDW-1:0]  owner_inc_d;

  // First requester with want set, scanning from start upward and wrapping.
  // The modulo keeps non-power-of-2 NREQ from ever selecting an index >= NREQ.
  function automatic logic [IDW-1:0] pick(input logic [IDW-1:0]  start,
                                          input logic [NREQ-1:0] want);
    logic [IDW-1:0] sel;
    logic           found;
    int             idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(start) + k) % NREQ;
      if (!found && want[IDW'(idx)]) begin
        sel   = IDW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign owned       = (state_q == S_OWNED);
  // A beat fires only for the owner, only when the FIFO is ready, never in reset.
  assign fire        = owned & !RST & req_enq_ena_i[owner_q] & out_enq_rdy_i;
  assign last_beat   = (burst_q == BW'(MAX_BURST - 1));
  // Release on the final beat of a burst, or when the owner has gone quiet.
  assign release_d   = owned & ((fire & last_beat) | (!req_want_i[owner_q] & !fire));
  assign owner_inc_d = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);

  // Ready goes only to the owner and mirrors FIFO ready with no added latency.
  always_comb begin
    req_enq_rdy_o = '0;
    if (owned && !RST) req_enq_rdy_o[owner_q] = out_enq_rdy_i;
  end

  assign out_enq_ena_o = fire;
  assign out_enq_v_o   = req_enq_v_i[int'(owner_q)*WIDTH +: WIDTH];
  assign grant_valid_o = owned;
  assign grant_id_o    = owned ? owner_q : '0;
  assign err_proto_o   = err_q;

  // Grant FSM: arbitrate in IDLE, count beats in OWNED, chain owners without a gap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // Any enq from a requester that was not offered ready is a protocol error.
      if (|(req_enq_ena_i & ~req_enq_rdy_o)) err_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (|req_want_i) begin
            owner_q <= pick(rr_ptr_q, req_want_i);
            burst_q <= '0;
            state_q <= S_OWNED;
          end
        end
        S_OWNED: begin
          if (release_d) begin
            rr_ptr_q <= owner_inc_d;
            if (|req_want_i) begin
              // Scan starts after the old owner, so it is considered last.
              owner_q <= pick(owner_inc_d, req_want_i);
              burst_q <= '0;
            end else begin
              owner_q <= '0;
              burst_q <= '0;
              state_q <= S_IDLE;
            end
          end else if (fire) begin
            burst_q <= burst_q + BW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_enq_arbiter.sv
// Directed bench for pong_enq_arbiter: a cycle table for reset, lone-requester
// chaining and full round-robin, then hand sequences for stall, want drop,
// protocol error and mid-burst reset.
module tb_pong_enq_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 96;
  localparam int IDW   = 2;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic [NREQ-1:0]       req_want_i    = '0;
  logic [NREQ-1:0]       req_enq_ena_i = '0;
  logic [NREQ*WIDTH-1:0] req_enq_v_i;
  logic [NREQ-1:0]       req_enq_rdy_o;
  logic                  out_enq_ena_o;
  logic [WIDTH-1:0]      out_enq_v_o;
  logic                  out_enq_rdy_i = 1'b1;
  logic                  grant_valid_o;
  logic [IDW-1:0]        grant_id_o;
  logic                  err_proto_o;

  pong_enq_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_want_i   (req_want_i),
    .req_enq_ena_i(req_enq_ena_i),
    .req_enq_v_i  (req_enq_v_i),
    .req_enq_rdy_o(req_enq_rdy_o),
    .out_enq_ena_o(out_enq_ena_o),
    .out_enq_v_o  (out_enq_v_o),
    .out_enq_rdy_i(out_enq_rdy_i),
    .grant_valid_o(grant_valid_o),
    .grant_id_o   (grant_id_o),
    .err_proto_o  (err_proto_o)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] want;
    logic [3:0] ena;
    logic       frdy;
    logic [3:0] e_rdy;
    logic       e_ena;
    logic       e_vld;
    logic [1:0] e_id;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [WIDTH-1:0] slice_of(input int i);
    logic [WIDTH-1:0] s;
    s = {32'hC0DE_0000 + 32'(i), 32'h1234_5678 ^ 32'(i), 32'hFACE_0000 | 32'(i)};
    return s;
  endfunction

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, settle, then let the caller sample.
  task automatic cyc(input logic rst, input logic [3:0] want, input logic [3:0] ena, input logic frdy);
    @(negedge CLK);
    RST           = rst;
    req_want_i    = want;
    req_enq_ena_i = ena;
    out_enq_rdy_i = frdy;
    #2;
  endtask

  task automatic exp_out(input string nm, input logic [3:0] e_rdy, input logic e_ena,
                         input logic e_vld, input logic [1:0] e_id, input logic e_err);
    chk({nm, ".rdy"}, WIDTH'(req_enq_rdy_o), WIDTH'(e_rdy));
    chk({nm, ".ena"}, WIDTH'(out_enq_ena_o), WIDTH'(e_ena));
    chk({nm, ".vld"}, WIDTH'(grant_valid_o), WIDTH'(e_vld));
    chk({nm, ".id"},  WIDTH'(grant_id_o),    WIDTH'(e_id));
    chk({nm, ".err"}, WIDTH'(err_proto_o),   WIDTH'(e_err));
    if (e_ena) chk({nm, ".v"}, out_enq_v_o, slice_of(int'(e_id)));
  endtask

  task automatic addv(input logic rst, input logic [3:0] want, input logic [3:0] ena,
                      input logic frdy, input logic [3:0] e_rdy, input logic e_ena,
                      input logic e_vld, input logic [1:0] e_id, input logic e_err);
    vec_t v;
    v.rst = rst; v.want = want; v.ena = ena; v.frdy = frdy;
    v.e_rdy = e_rdy; v.e_ena = e_ena; v.e_vld = e_vld; v.e_id = e_id; v.e_err = e_err;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    cyc(1'b1, 4'h0, 4'h0, 1'b1);
    cyc(1'b1, 4'h0, 4'h0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) req_enq_v_i[i*WIDTH +: WIDTH] = slice_of(i);

    // Idle after reset
    addv(0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 2'd0, 0);
    // Lone requester 0: one arbitration cycle, 4 beats, chained re-grant with no gap
    addv(0, 4'h1, 4'h0, 1, 4'h0, 0, 0, 2'd0, 0);
    for (int k = 0; k < 5; k++) addv(0, 4'h1, 4'h1, 1, 4'h1, 1, 1, 2'd0, 0);
    // Want drops: still owned this cycle, released at the edge
    addv(0, 4'h0, 4'h0, 1, 4'h1, 0, 1, 2'd0, 0);
    addv(1, 4'h0, 4'h0, 1, 4'h0, 0, 0, 2'd0, 0);
    // All four want: 0,1,2,3,0 with 4 beats each, back to back
    addv(0, 4'hF, 4'h0, 1, 4'h0, 0, 0, 2'd0, 0);
    for (int k = 0; k < 17; k++) begin
      logic [1:0] o;
      logic [3:0] oh;
      o  = 2'((k / 4) % 4);
      oh = 4'b0001 << o;
      addv(0, 4'hF, oh, 1, oh, 1, 1, o, 0);
    end

    do_reset();
    for (int r = 0; r < tbl.size(); r++) begin
      cyc(tbl[r].rst, tbl[r].want, tbl[r].ena, tbl[r].frdy);
      exp_out($sformatf("tbl%0d", r), tbl[r].e_rdy, tbl[r].e_ena, tbl[r].e_vld, tbl[r].e_id, tbl[r].e_err);
    end

    // Owner 2 stalls mid-burst; burst count must not advance while FIFO is not ready
    do_reset();
    cyc(0, 4'b0100, 4'h0, 1);    exp_out("stall.arb", 4'h0, 0, 0, 2'd0, 0);
    cyc(0, 4'b0100, 4'b0100, 1); exp_out("stall.b1", 4'b0100, 1, 1, 2'd2, 0);
    cyc(0, 4'b0100, 4'b0100, 1); exp_out("stall.b2", 4'b0100, 1, 1, 2'd2, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 4'b1100, 4'h0, 0);  exp_out($sformatf("stall.hold%0d", k), 4'h0, 0, 1, 2'd2, 0);
    end
    cyc(0, 4'b1100, 4'b0100, 1); exp_out("stall.b3", 4'b0100, 1, 1, 2'd2, 0);
    cyc(0, 4'b1100, 4'b0100, 1); exp_out("stall.b4", 4'b0100, 1, 1, 2'd2, 0);
    cyc(0, 4'b1100, 4'b1000, 1); exp_out("stall.next", 4'b1000, 1, 1, 2'd3, 0);

    // Owner 1 drops want after 2 beats; release next cycle, owner 3, pointer 2
    do_reset();
    cyc(0, 4'b1010, 4'h0, 1);    exp_out("drop.arb", 4'h0, 0, 0, 2'd0, 0);
    cyc(0, 4'b1010, 4'b0010, 1); exp_out("drop.b1", 4'b0010, 1, 1, 2'd1, 0);
    cyc(0, 4'b1010, 4'b0010, 1); exp_out("drop.b2", 4'b0010, 1, 1, 2'd1, 0);
    cyc(0, 4'b1000, 4'h0, 1);    exp_out("drop.rel", 4'b0010, 0, 1, 2'd1, 0);
    cyc(0, 4'b1000, 4'h0, 1);    exp_out("drop.own3", 4'b1000, 0, 1, 2'd3, 0);
    chk("drop.rr_ptr", WIDTH'(dut.rr_ptr_q), WIDTH'(2'd2));

    // Stray ENA from requester 0 while 3 owns: not forwarded, sticky error
    cyc(0, 4'b1000, 4'b0001, 1); exp_out("err.pulse", 4'b1000, 0, 1, 2'd3, 0);
    cyc(0, 4'b1000, 4'h0, 1);    exp_out("err.set", 4'b1000, 0, 1, 2'd3, 1);
    cyc(0, 4'b1000, 4'b1000, 1); exp_out("err.beat", 4'b1000, 1, 1, 2'd3, 1);
    cyc(0, 4'b1000, 4'h0, 1);    exp_out("err.sticky", 4'b1000, 0, 1, 2'd3, 1);

    // Reset mid-burst: ENA ignored while RST is high, everything clear afterwards
    cyc(1, 4'b1000, 4'b1000, 1);
    chk("rst.ena", WIDTH'(out_enq_ena_o), WIDTH'(1'b0));
    chk("rst.rdy", WIDTH'(req_enq_rdy_o), WIDTH'(4'h0));
    cyc(0, 4'h0, 4'h0, 1);       exp_out("rst.after", 4'h0, 0, 0, 2'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
